// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption-side key scheduler: expands a cipher key up to round 10 (or takes
// the round-10 key directly), then walks the schedule backwards, one round key per handshake.
module aes_inv_key_schedule #(
  parameter int unsigned ALLOW_LAST_LOAD = 32'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic         in_is_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  state_t       state_r;
  logic [127:0] key_r;
  logic [3:0]   round_r;

  logic [31:0]  w0_s, w1_s, w2_s, w3_s, w23_s;
  logic [31:0]  sub_in_s, sub_out_s;
  logic [31:0]  f0_s, f1_s, f2_s, f3_s;
  logic [31:0]  i0_s, i1_s, i2_s, i3_s;
  logic         load_last_s;

  assign {w0_s, w1_s, w2_s, w3_s} = key_r;
  assign w23_s = w2_s ^ w3_s;

  // Single shared SubWord: backward steps need the already-updated w3 (= w2^w3).
  always_comb begin
    sub_in_s = 32'd0;
    if (state_r == EMIT) begin
      sub_in_s = rot_word(w23_s);
    end else begin
      sub_in_s = rot_word(w3_s);
    end
  end

  assign sub_out_s = sub_word(sub_in_s);

  assign f0_s = w0_s ^ sub_out_s ^ rcon(round_r + 4'd1);
  assign f1_s = w1_s ^ f0_s;
  assign f2_s = w2_s ^ f1_s;
  assign f3_s = w3_s ^ f2_s;

  assign i3_s = w23_s;
  assign i2_s = w2_s ^ w1_s;
  assign i1_s = w1_s ^ w0_s;
  assign i0_s = w0_s ^ sub_out_s ^ rcon(round_r);

  assign load_last_s = in_is_last && (ALLOW_LAST_LOAD != 32'd0);

  // Load / expand / emit sequencing; clear aborts to IDLE without touching key_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      key_r   <= 128'd0;
      round_r <= 4'd0;
    end else if (clear) begin
      state_r <= IDLE;
      round_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            key_r <= in_key;
            if (load_last_s) begin
              round_r <= 4'd10;
              state_r <= EMIT;
            end else begin
              round_r <= 4'd0;
              state_r <= EXPAND;
            end
          end
        end
        EXPAND: begin
          key_r <= {f0_s, f1_s, f2_s, f3_s};
          if (round_r >= 4'd9) begin
            round_r <= 4'd10;
            state_r <= EMIT;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (round_r == 4'd0) begin
              state_r <= IDLE;
            end else begin
              key_r   <= {i0_s, i1_s, i2_s, i3_s};
              round_r <= round_r - 4'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          round_r <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == EMIT);
  assign out_key   = key_r;
  assign out_round = round_r;
  assign out_last  = (state_r == EMIT) && (round_r == 4'd0);

endmodule
